// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one registered ALU between two valid/ready requesters.
// One command is in flight at a time; its result is returned tagged with the requester id.
module alu_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int FUN_W = 4
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FUN_W-1:0] req0_fun,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FUN_W-1:0] req1_fun,

  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [FUN_W-1:0] ALU_FUN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             Shift_Flag,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  // state | meaning
  // IDLE  | no command in flight; grant decided combinationally
  // EXEC  | ALU inputs held stable; ALU registers its result
  // CAPT  | registered ALU result captured into the response
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_id;
  logic cur_id;
  logic grant_valid;
  logic grant_id;
  logic rsp_done;

  assign rsp_done = rsp_valid && rsp_ready;

  // Tie goes to the requester that did not complete most recently.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_id;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_valid) state_nxt = EXEC;
      EXEC: state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant_valid && (grant_id == 1'b0);
    req1_ready = grant_valid && (grant_id == 1'b1);
    busy       = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      cur_id    <= 1'b0;
      last_id   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            ALU_A   <= grant_id ? req1_a   : req0_a;
            ALU_B   <= grant_id ? req1_b   : req0_b;
            ALU_FUN <= grant_id ? req1_fun : req0_fun;
            cur_id  <= grant_id;
          end
        end
        CAPT: begin
          rsp_data  <= ALU_OUT;
          rsp_flags <= {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          // Priority moves only when the response is consumed, not at accept.
          if (rsp_done) begin
            rsp_valid <= 1'b0;
            last_id   <= rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: behavioural ALU beside the DUT, transaction-level reference model,
// directed scenarios followed by a randomized phase.
module tb_alu_rr_arbiter;

  logic        CLK;
  logic        RST;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_fun, req1_fun;
  logic [15:0] ALU_A, ALU_B, ALU_OUT;
  logic [3:0]  ALU_FUN;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_flags;

  alu_rr_arbiter #(.WIDTH(16), .FUN_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fun(req1_fun),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag),
    .Shift_Flag(Shift_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU behaviour: result in [19:4], flags {Arith,Logic,CMP,Shift} in [3:0].
  function automatic logic [19:0] alu_ref(logic [15:0] a, logic [15:0] b, logic [3:0] fun);
    logic [15:0] r;
    logic [3:0]  f;
    r = '0;
    f = 4'b0000;
    case (fun)
      4'd0:  begin r = a + b;                     f = 4'b1000; end
      4'd1:  begin r = a - b;                     f = 4'b1000; end
      4'd2:  begin r = a * b;                     f = 4'b1000; end
      4'd3:  begin r = (b != 0) ? a / b : 16'd0;  f = 4'b1000; end
      4'd4:  begin r = a & b;                     f = 4'b0100; end
      4'd5:  begin r = a | b;                     f = 4'b0100; end
      4'd6:  begin r = ~(a & b);                  f = 4'b0100; end
      4'd7:  begin r = ~(a | b);                  f = 4'b0100; end
      4'd8:  begin r = a ^ b;                     f = 4'b0100; end
      4'd9:  begin r = ~(a ^ b);                  f = 4'b0100; end
      4'd10: begin r = (a == b) ? 16'd1 : 16'd0;  f = 4'b0010; end
      4'd11: begin r = (a > b)  ? 16'd2 : 16'd0;  f = 4'b0010; end
      4'd12: begin r = (a < b)  ? 16'd3 : 16'd0;  f = 4'b0010; end
      4'd13: begin r = a >> 1;                    f = 4'b0001; end
      4'd14: begin r = a << 1;                    f = 4'b0001; end
      default: begin r = '0;                      f = 4'b0000; end
    endcase
    return {r, f};
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      ALU_OUT <= '0;
      {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} <= 4'b0000;
    end else begin
      {ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} <= alu_ref(ALU_A, ALU_B, ALU_FUN);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester drivers: pend[n] commands outstanding with the fields below.
  int          pend[2];
  logic [15:0] fa[2], fb[2];
  logic [3:0]  ff[2];
  bit          rnd;
  bit          rdy;

  // Reference model: one transaction in flight, response 2 edges after accept.
  bit          m_out, m_rv, m_last, m_id, m_rid;
  int          m_age, m_ndone;
  logic [15:0] m_a, m_b, m_data;
  logic [3:0]  m_fun, m_flags;

  logic [20:0] obs_q[$];

  task automatic model_reset();
    m_out = 0; m_rv = 0; m_last = 1; m_id = 0; m_rid = 0; m_age = 0;
    m_a = '0; m_b = '0; m_fun = '0; m_data = '0; m_flags = '0;
  endtask

  task automatic new_cmd(input int n);
    fa[n] = 16'($urandom);
    fb[n] = 16'($urandom_range(0, 255));
    ff[n] = 4'($urandom_range(0, 15));
  endtask

  task automatic set_cmd(input int n, input int cnt, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f);
    pend[n] = cnt; fa[n] = a; fb[n] = b; ff[n] = f;
  endtask

  task automatic cyc();
    bit v0, v1, gv, gid;
    logic [19:0] r;
    if (rnd) begin
      rdy = ($urandom_range(0, 3) != 0);
      for (int n = 0; n < 2; n++) begin
        if (pend[n] == 0 && $urandom_range(0, 3) == 0) begin
          pend[n] = $urandom_range(1, 3);
          new_cmd(n);
        end else if (pend[n] != 0 && $urandom_range(0, 15) == 0) begin
          pend[n] = 0;
        end
      end
    end
    req0_valid = (pend[0] != 0); req0_a = fa[0]; req0_b = fb[0]; req0_fun = ff[0];
    req1_valid = (pend[1] != 0); req1_a = fa[1]; req1_b = fb[1]; req1_fun = ff[1];
    rsp_ready  = rdy;
    #2;
    v0  = req0_valid;
    v1  = req1_valid;
    gv  = !m_out && (v0 || v1);
    gid = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", 32'(req0_ready), 32'(gv && !gid));
    chk("req1_ready", 32'(req1_ready), 32'(gv && gid));
    chk("busy",       32'(busy),       32'(m_out));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_rv));
    chk("rsp_id",     32'(rsp_id),     32'(m_rid));
    chk("rsp_data",   32'(rsp_data),   32'(m_data));
    chk("rsp_flags",  32'(rsp_flags),  32'(m_flags));
    chk("alu_a",      32'(ALU_A),      32'(m_a));
    chk("alu_b",      32'(ALU_B),      32'(m_b));
    chk("alu_fun",    32'(ALU_FUN),    32'(m_fun));
    if (rsp_valid === 1'b1 && rdy) obs_q.push_back({rsp_id, rsp_data, rsp_flags});
    if (RST) begin
      model_reset();
    end else if (m_rv && rdy) begin
      m_rv = 0; m_out = 0; m_last = m_rid; m_ndone++;
    end else if (m_out) begin
      m_age++;
      if (m_age == 2) begin
        r = alu_ref(m_a, m_b, m_fun);
        m_rv = 1; m_rid = m_id; m_data = r[19:4]; m_flags = r[3:0];
      end
    end else if (gv) begin
      m_out = 1; m_age = 0; m_id = gid;
      m_a = fa[gid]; m_b = fb[gid]; m_fun = ff[gid];
      pend[gid]--;
      if (rnd) new_cmd(gid);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_rsp(input string tag, input int idx, input logic [20:0] exp);
    logic [20:0] o;
    o = (idx < obs_q.size()) ? obs_q[idx] : 21'h1fffff;
    chk(tag, 32'(o), 32'(exp));
  endtask

  initial begin
    rnd = 0; rdy = 1; pend[0] = 0; pend[1] = 0;
    set_cmd(0, 0, 0, 0, 0); set_cmd(1, 0, 0, 0, 0);
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_a = 0; req0_b = 0; req0_fun = 0; req1_a = 0; req1_b = 0; req1_fun = 0;
    m_ndone = 0;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    model_reset();

    // Single add from requester 0.
    set_cmd(0, 1, 16'd10, 16'd10, 4'b0000);
    run(6);
    chk("t1_count", 32'(obs_q.size()), 32'd1);
    chk_rsp("t1_rsp", 0, {1'b0, 16'd20, 4'b1000});
    obs_q.delete();

    // Both valid right after reset: alternation starting with 0.
    RST = 1; run(1); RST = 0;
    set_cmd(0, 3, 16'd20, 16'd10, 4'b0001);
    set_cmd(1, 3, 16'd40, 16'd20, 4'b1011);
    run(28);
    chk("t2_count", 32'(obs_q.size()), 32'd6);
    chk_rsp("t2_rsp0", 0, {1'b0, 16'd10, 4'b1000});
    chk_rsp("t2_rsp1", 1, {1'b1, 16'd2,  4'b0010});
    for (int i = 2; i < 6; i++) chk_rsp("t2_alt", i, (i % 2 == 0) ? {1'b0, 16'd10, 4'b1000}
                                                                   : {1'b1, 16'd2, 4'b0010});
    obs_q.delete();

    // Backpressure while requester 0 waits.
    set_cmd(1, 1, 16'd18, 16'd10, 4'b0100);
    run(1);
    set_cmd(0, 1, 16'd7, 16'd3, 4'b0000);
    rdy = 0;
    run(7);
    rdy = 1;
    run(8);
    chk("t3_count", 32'(obs_q.size()), 32'd2);
    chk_rsp("t3_rsp0", 0, {1'b1, 16'd2,  4'b0100});
    chk_rsp("t3_rsp1", 1, {1'b0, 16'd10, 4'b1000});
    obs_q.delete();

    // Reset during EXEC drops the command.
    set_cmd(0, 1, 16'd5, 16'd3, 4'b0000);
    run(1);
    RST = 1; run(1); RST = 0;
    run(3);
    chk("t4_dropped", 32'(obs_q.size()), 32'd0);
    set_cmd(1, 1, 16'd9, 16'd4, 4'b0001);
    run(6);
    chk_rsp("t4_rsp", 0, {1'b1, 16'd5, 4'b1000});
    obs_q.delete();

    // Undefined function code.
    set_cmd(0, 1, 16'd2, 16'd2, 4'b1111);
    run(6);
    chk_rsp("t5_rsp", 0, {1'b0, 16'd0, 4'b0000});
    obs_q.delete();

    // Shift from requester 1 while requester 0 withdraws during EXEC.
    set_cmd(1, 1, 16'd20, 16'd20, 4'b1101);
    set_cmd(0, 1, 16'd3, 16'd3, 4'b0000);
    run(1);
    pend[0] = 0;
    run(7);
    chk("t6_count", 32'(obs_q.size()), 32'd1);
    chk_rsp("t6_rsp", 0, {1'b1, 16'd10, 4'b0001});
    obs_q.delete();

    // Randomized traffic with random backpressure and withdrawals.
    m_ndone = 0;
    rnd = 1;
    run(600);
    rnd = 0; pend[0] = 0; pend[1] = 0; rdy = 1;
    run(8);
    chk("rnd_count", 32'(obs_q.size()), 32'(m_ndone));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one registered 16-bit ALU between two requesters.
- The ALU has one-cycle latency: its outputs are registered on the CLK edge that samples its inputs.
- Each requester uses a valid/ready request port. The block arbitrates round-robin, drives the ALU operands and function, and captures the result and flags.
- The result is returned on a single response port tagged with the requester id. Sits between command sources (sequencer/CPU stub) and the ALU instance.

Parameters:
- WIDTH, 16, operand/result width.
- FUN_W, 4, ALU function code width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_fun  in  FUN_W  requester 0 function code.
- req1_valid  in  1  requester 1 has a command.
- req1_ready  out  1  requester 1 command accepted this cycle.
- req1_a, req1_b, req1_fun  in  WIDTH/WIDTH/FUN_W  requester 1 command fields.
- ALU_A  out  WIDTH  operand A to the ALU.
- ALU_B  out  WIDTH  operand B to the ALU.
- ALU_FUN  out  FUN_W  function code to the ALU.
- ALU_OUT  in  WIDTH  registered ALU result.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  registered ALU class flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  id of the requester that issued the command.
- rsp_data  out  WIDTH  captured ALU_OUT.
- rsp_flags  out  4  captured {Arith,Logic,CMP,Shift}.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- State machine IDLE -> EXEC -> CAPT -> RESP -> IDLE. All state and output registers update on the CLK rising edge only.
- Reset (RST=1 at an edge), from any state:
  - state goes to IDLE; priority pointer last_id = 1, so requester 0 wins the first tie.
  - ALU_A, ALU_B, ALU_FUN = 0.
  - rsp_valid, rsp_id, rsp_data, rsp_flags = 0; busy = 0.
  - An in-flight command is discarded and produces no response.
- Grant logic (combinational, IDLE only):
  - Only reqN_valid high: grant N.
  - Both high: grant the id != last_id.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high per cycle; both are 0 outside IDLE.
- IDLE, granted at edge E0: latch granted a/b/fun into ALU_A/ALU_B/ALU_FUN, latch the id, go to EXEC.
- EXEC: hold the ALU inputs stable. The ALU registers its result at edge E1. Go to CAPT.
- CAPT: at edge E2, capture ALU_OUT into rsp_data and the four flags into rsp_flags, set rsp_id and rsp_valid=1, go to RESP.
- Latency: rsp_valid rises exactly 2 cycles after the accept edge.
- RESP:
  - rsp_valid && rsp_ready at an edge: rsp_valid goes to 0, last_id becomes rsp_id, go to IDLE.
  - Otherwise hold rsp_valid and all rsp_* fields stable indefinitely.
  - ALU inputs keep their values until the next accept.
- Peak throughput with rsp_ready=1: one command per 4 cycles.
- Requester protocol: reqN_valid and fields are held until reqN_ready. Requests arriving outside IDLE wait, with no loss. Dropping valid before ready is legal and simply withdraws the request.
- The function code is passed through unchecked. Undefined code 4'b1111 yields whatever the ALU returns (0, flags 0000).
- last_id updates only on response completion, never on accept.
- Fairness: two continuously valid requesters alternate 0,1,0,1...
- rsp_data/rsp_flags stay unchanged outside CAPT edges; no X after reset.

Test Plan:
- Reset, then req0 = {A=10, B=10, fun=0000}, rsp_ready=1 -> req0_ready pulses 1 cycle; rsp_valid 2 cycles after accept; rsp_id=0, rsp_data=20, rsp_flags=1000; busy high for 3 cycles.
- Both valid from reset: req0 = {20,10,0001}, req1 = {40,20,1011}, rsp_ready=1 -> first response id 0, data 10, flags 1000; second response id 1, data 2, flags 0010; then 0,1 alternation for 6 commands.
- Backpressure: req1 = {18,10,0100}, rsp_ready=0 for 5 cycles -> rsp_valid held with data 2 (18&10), flags 0100 stable; req0 (valid meanwhile) gets no ready until the cycle after rsp_ready=1.
- Reset mid-operation: assert RST in EXEC -> next cycle IDLE, rsp_valid=0, ALU_A/B/FUN=0, no response; then a req1-only command is still granted normally.
- Undefined function: req0 = {2,2,1111} -> rsp_data=0, rsp_flags=0000, rsp_id=0.
- Shift: req1 = {20,20,1101} -> rsp_data=10, rsp_flags=0001; request withdrawn (valid dropped in EXEC state of another op) -> no response for it.
